// File: rtl/riscv_lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: operation and size
// encodings, exception causes, controller state and byte-enable decode.
package riscv_lsu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_LOAD_U = 3'd2,
        OP_STORE  = 3'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    function automatic logic [3:0] be_decode(input mem_size_e size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: be_decode = 4'b0001 << off;
            SIZE_HALF: be_decode = 4'b0011 << {off[1], 1'b0};
            default:   be_decode = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_extend.sv
// Load lane select: picks the byte/halfword addressed by the low address bits
// and sign- or zero-extends it to 32 bits; words pass through untouched.
module riscv_lsu_extend
    import riscv_lsu_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  mem_size_e   size,
    input  logic [1:0]  byte_off,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (byte_off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SIZE_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Memory-stage load/store controller: accepts one request at a time, drives a
// level-request data bus, extends load data and reports misalign/timeout faults.
module riscv_lsu_ctrl
    import riscv_lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  mem_op_in,
    input  logic [1:0]  mem_size_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_read_req,
    output logic        dmem_write_req,
    input  logic        dmem_read_ack,
    input  logic        dmem_write_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        rsp_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output lsu_state_e  dbg_state
);

    localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_CYCLES[15:0];

    lsu_state_e  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    mem_op_e     op_q;
    mem_size_e   size_q;
    logic [15:0] wait_cnt;

    mem_size_e   size_norm;
    logic        op_legal;
    logic        is_store_in;
    logic        misaligned;
    logic        accept;
    logic [31:0] ext_data;

    // Handshake: a request is taken when req_valid is high with a real op while
    // IDLE; stall_out holds the pipeline (and its request) until completion.
    assign op_legal    = (mem_op_in == OP_LOAD) || (mem_op_in == OP_LOAD_U) || (mem_op_in == OP_STORE);
    assign is_store_in = (mem_op_in == OP_STORE);
    assign size_norm   = (mem_size_in == 2'd0) ? SIZE_BYTE :
                         (mem_size_in == 2'd1) ? SIZE_HALF : SIZE_WORD;
    assign misaligned  = ((size_norm == SIZE_HALF) && addr_in[0]) ||
                         ((size_norm == SIZE_WORD) && (addr_in[1:0] != 2'b00));
    assign accept      = (state == ST_IDLE) && req_valid && op_legal;
    assign stall_out   = (state != ST_IDLE) || accept;

    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_be    = ((state == ST_READ) || (state == ST_WRITE)) ? be_decode(size_q, addr_q[1:0]) : 4'b0000;
    assign dmem_wdata = (size_q == SIZE_BYTE) ? {4{wdata_q[7:0]}} :
                        (size_q == SIZE_HALF) ? {2{wdata_q[15:0]}} : wdata_q;
    assign dbg_state  = state;

    riscv_lsu_extend u_extend (
        .rdata       (dmem_rdata),
        .size        (size_q),
        .byte_off    (addr_q[1:0]),
        .is_unsigned (op_q == OP_LOAD_U),
        .data        (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            op_q           <= OP_NONE;
            size_q         <= SIZE_BYTE;
            wait_cnt       <= '0;
            dmem_read_req  <= 1'b0;
            dmem_write_req <= 1'b0;
            rsp_valid      <= 1'b0;
            load_data      <= '0;
            exc_valid      <= 1'b0;
            exc_cause      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= addr_in;
                        wdata_q  <= wdata_in;
                        op_q     <= mem_op_e'(mem_op_in);
                        size_q   <= size_norm;
                        wait_cnt <= '0;
                        if (misaligned) begin
                            state     <= ST_FAULT;
                            exc_valid <= 1'b1;
                            exc_cause <= is_store_in ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                        end else if (is_store_in) begin
                            state          <= ST_WRITE;
                            dmem_write_req <= 1'b1;
                        end else begin
                            state         <= ST_READ;
                            dmem_read_req <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // An ack landing on the expiry cycle still completes the load.
                    if (dmem_read_ack) begin
                        state         <= ST_IDLE;
                        dmem_read_req <= 1'b0;
                        rsp_valid     <= 1'b1;
                        load_data     <= ext_data;
                    end else if (wait_cnt == TIMEOUT_LIM) begin
                        state         <= ST_IDLE;
                        dmem_read_req <= 1'b0;
                        exc_valid     <= 1'b1;
                        exc_cause     <= EXC_LOAD_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_WRITE: begin
                    if (dmem_write_ack) begin
                        state          <= ST_IDLE;
                        dmem_write_req <= 1'b0;
                        rsp_valid      <= 1'b1;
                    end else if (wait_cnt == TIMEOUT_LIM) begin
                        state          <= ST_IDLE;
                        dmem_write_req <= 1'b0;
                        exc_valid      <= 1'b1;
                        exc_cause      <= EXC_STORE_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed bench for riscv_lsu_ctrl: loads, stores, faults, timeout,
// back-to-back accepts and mid-transaction reset against hand-computed values.
module tb_riscv_lsu_ctrl;
    import riscv_lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [2:0]  mem_op_in;
    logic [1:0]  mem_size_in;
    logic [31:0] addr_in, wdata_in;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_read_req, dmem_write_req, dmem_read_ack, dmem_write_ack;
    logic        stall_out, rsp_valid, exc_valid;
    logic [31:0] load_data;
    logic [3:0]  exc_cause;
    lsu_state_e  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .mem_op_in(mem_op_in),
        .mem_size_in(mem_size_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_read_req(dmem_read_req), .dmem_write_req(dmem_write_req),
        .dmem_read_ack(dmem_read_ack), .dmem_write_ack(dmem_write_ack),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .rsp_valid(rsp_valid),
        .load_data(load_data), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .dbg_state(dbg_state)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] rdata, input int waits,
                              output logic [3:0] be_o, output logic [31:0] addr_o,
                              output logic [31:0] data_o, output int stall_cnt,
                              output int rsp_cnt, output int exc_cnt);
        stall_cnt = 0; rsp_cnt = 0; exc_cnt = 0; data_o = '0;
        req_valid = 1'b1; mem_op_in = op; mem_size_in = size; addr_in = addr; wdata_in = '0;
        #1 stall_cnt += int'(stall_out);
        next_cycle();
        req_valid = 1'b0;
        #1;
        be_o = dmem_be; addr_o = dmem_addr;
        for (int i = 0; i < waits; i++) begin
            stall_cnt += int'(stall_out);
            next_cycle();
            #1;
        end
        dmem_read_ack = 1'b1; dmem_rdata = rdata;
        #1 stall_cnt += int'(stall_out);
        next_cycle();
        dmem_read_ack = 1'b0; dmem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            rsp_cnt += int'(rsp_valid);
            exc_cnt += int'(exc_valid);
            if (rsp_valid) data_o = load_data;
            stall_cnt += int'(stall_out);
            next_cycle();
        end
    endtask

    task automatic drive_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [3:0] be_o, output logic [31:0] addr_o,
                               output logic [31:0] bus_o, output logic wreq_o, output int rsp_cnt);
        rsp_cnt = 0;
        req_valid = 1'b1; mem_op_in = 3'd3; mem_size_in = size; addr_in = addr; wdata_in = wdata;
        next_cycle();
        req_valid = 1'b0;
        #1;
        be_o = dmem_be; addr_o = dmem_addr; bus_o = dmem_wdata; wreq_o = dmem_write_req;
        dmem_write_ack = 1'b1;
        next_cycle();
        dmem_write_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 rsp_cnt += int'(rsp_valid);
            next_cycle();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; mem_op_in = '0; mem_size_in = '0; addr_in = '0;
        wdata_in = '0; dmem_read_ack = 1'b0; dmem_write_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({dmem_read_req, dmem_write_req, dmem_be} !== 6'b0) begin n_err++; $display("FAIL reset_bus: got req=%b%b be=%b, want 0", dmem_read_req, dmem_write_req, dmem_be); end
        n_vec++; if ({rsp_valid, exc_valid, exc_cause} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got rsp=%b exc=%b cause=%0d, want 0", rsp_valid, exc_valid, exc_cause); end
        n_vec++; if (load_data !== 32'h0 || stall_out !== 1'b0) begin n_err++; $display("FAIL reset_data: got load_data=%h stall=%b, want 0", load_data, stall_out); end
        @(negedge clk) reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_idle();
        req_valid = 1'b1; mem_op_in = 3'd0; mem_size_in = 2'd2; addr_in = 32'h100;
        dmem_read_ack = 1'b1; dmem_write_ack = 1'b1;
        #1;
        n_vec++; if (stall_out !== 1'b0) begin n_err++; $display("FAIL idle_none_stall: got %b want 0", stall_out); end
        next_cycle();
        #1;
        n_vec++; if ({dmem_read_req, dmem_write_req, rsp_valid, exc_valid} !== 4'b0 || dbg_state !== ST_IDLE)
            begin n_err++; $display("FAIL idle_none: got req=%b%b rsp=%b exc=%b state=%0d, want all 0", dmem_read_req, dmem_write_req, rsp_valid, exc_valid, dbg_state); end
        req_valid = 1'b0; dmem_read_ack = 1'b0; dmem_write_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_loads();
        logic [3:0] be; logic [31:0] a, d; int st, rs, ex;
        drive_load(3'd1, 2'd0, 32'h0000_1003, 32'h80FF_FF00, 2, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b1000 || a !== 32'h1000) begin n_err++; $display("FAIL lb_bus: got be=%b addr=%h want 1000 00001000", be, a); end
        n_vec++; if (d !== 32'hFFFF_FF80 || rs !== 1) begin n_err++; $display("FAIL lb_data: got %h rsp=%0d want ffffff80 rsp=1", d, rs); end
        n_vec++; if (st !== 4) begin n_err++; $display("FAIL lb_stall: got %0d stall cycles want 4", st); end
        drive_load(3'd2, 2'd1, 32'h0000_2002, 32'hBEEF_1234, 0, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b1100 || d !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu: got be=%b data=%h want 1100 0000beef", be, d); end
        drive_load(3'd1, 2'd1, 32'h0000_2000, 32'hBEEF_8234, 1, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b0011 || d !== 32'hFFFF_8234) begin n_err++; $display("FAIL lh: got be=%b data=%h want 0011 ffff8234", be, d); end
        drive_load(3'd2, 2'd0, 32'h0000_2001, 32'h0000_9A00, 0, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b0010 || d !== 32'h0000_009A) begin n_err++; $display("FAIL lbu: got be=%b data=%h want 0010 0000009a", be, d); end
        drive_load(3'd1, 2'd3, 32'h0000_6000, 32'hDEAD_BEEF, 0, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b1111 || d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_size3: got be=%b data=%h want 1111 deadbeef", be, d); end
    endtask

    task automatic test_stores();
        logic [3:0] be; logic [31:0] a, w; logic wr; int rs;
        drive_store(2'd1, 32'h0000_3002, 32'h0000_A5A5, be, a, w, wr, rs);
        n_vec++; if (w !== 32'hA5A5_A5A5 || be !== 4'b1100 || a !== 32'h3000) begin n_err++; $display("FAIL sh_bus: got wdata=%h be=%b addr=%h want a5a5a5a5 1100 00003000", w, be, a); end
        n_vec++; if (wr !== 1'b1 || rs !== 1) begin n_err++; $display("FAIL sh_rsp: got wreq=%b rsp=%0d want 1 1", wr, rs); end
        drive_store(2'd0, 32'h0000_3001, 32'h1234_5677, be, a, w, wr, rs);
        n_vec++; if (w !== 32'h7777_7777 || be !== 4'b0010) begin n_err++; $display("FAIL sb_bus: got wdata=%h be=%b want 77777777 0010", w, be); end
        drive_store(2'd2, 32'h0000_3004, 32'h1122_3344, be, a, w, wr, rs);
        n_vec++; if (w !== 32'h1122_3344 || be !== 4'b1111 || a !== 32'h3004) begin n_err++; $display("FAIL sw_bus: got wdata=%h be=%b addr=%h want 11223344 1111 00003004", w, be, a); end
    endtask

    task automatic test_misaligned();
        logic [3:0] exp_cause [2];
        logic [2:0] op [2];
        logic [1:0] sz [2];
        logic [31:0] ad [2];
        op[0] = 3'd3; sz[0] = 2'd2; ad[0] = 32'h4001; exp_cause[0] = 4'd6;
        op[1] = 3'd1; sz[1] = 2'd1; ad[1] = 32'h4003; exp_cause[1] = 4'd4;
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1; mem_op_in = op[k]; mem_size_in = sz[k]; addr_in = ad[k];
            next_cycle();
            req_valid = 1'b0;
            #1;
            n_vec++; if (exc_valid !== 1'b1 || exc_cause !== exp_cause[k] || stall_out !== 1'b1)
                begin n_err++; $display("FAIL misalign_exc%0d: got exc=%b cause=%0d stall=%b want 1 %0d 1", k, exc_valid, exc_cause, stall_out, exp_cause[k]); end
            n_vec++; if (dmem_read_req !== 1'b0 || dmem_write_req !== 1'b0) begin n_err++; $display("FAIL misalign_noreq%0d: got req=%b%b want 00", k, dmem_read_req, dmem_write_req); end
            next_cycle();
            #1;
            n_vec++; if (exc_valid !== 1'b0 || stall_out !== 1'b0 || exc_cause !== exp_cause[k])
                begin n_err++; $display("FAIL misalign_end%0d: got exc=%b stall=%b cause=%0d want 0 0 %0d", k, exc_valid, stall_out, exc_cause, exp_cause[k]); end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        logic [3:0] be; logic [31:0] a, d; int st, rs, ex, req_cycles;
        for (int k = 0; k < 2; k++) begin
            req_cycles = 0;
            req_valid = 1'b1; mem_op_in = (k == 0) ? 3'd1 : 3'd3; mem_size_in = 2'd2; addr_in = 32'h5000;
            next_cycle();
            req_valid = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                #1 req_cycles += int'(dmem_read_req | dmem_write_req);
                next_cycle();
            end
            #1;
            n_vec++; if (req_cycles !== 5) begin n_err++; $display("FAIL timeout_req%0d: got %0d req cycles want 5", k, req_cycles); end
            n_vec++; if (exc_valid !== 1'b1 || exc_cause !== ((k == 0) ? 4'd5 : 4'd7) || rsp_valid !== 1'b0 || dmem_read_req !== 1'b0 || dmem_write_req !== 1'b0)
                begin n_err++; $display("FAIL timeout_exc%0d: got exc=%b cause=%0d rsp=%b req=%b%b", k, exc_valid, exc_cause, rsp_valid, dmem_read_req, dmem_write_req); end
            next_cycle();
        end
        drive_load(3'd1, 2'd2, 32'h0000_5004, 32'hCAFE_F00D, 4, be, a, d, st, rs, ex);
        n_vec++; if (rs !== 1 || ex !== 0 || d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL timeout_ack_wins: got rsp=%0d exc=%0d data=%h want 1 0 cafef00d", rs, ex, d); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; mem_op_in = 3'd2; mem_size_in = 2'd0; addr_in = 32'h1000;
        next_cycle();
        req_valid = 1'b0; dmem_read_ack = 1'b1; dmem_rdata = 32'h0000_00AB;
        next_cycle();
        dmem_read_ack = 1'b0; dmem_rdata = '0;
        req_valid = 1'b1; mem_op_in = 3'd3; mem_size_in = 2'd2; addr_in = 32'h7000; wdata_in = 32'h55AA_55AA;
        #1;
        n_vec++; if (rsp_valid !== 1'b1 || load_data !== 32'h0000_00AB || stall_out !== 1'b1)
            begin n_err++; $display("FAIL b2b_overlap: got rsp=%b data=%h stall=%b want 1 000000ab 1", rsp_valid, load_data, stall_out); end
        next_cycle();
        req_valid = 1'b0;
        #1;
        n_vec++; if (dmem_write_req !== 1'b1 || dmem_addr !== 32'h7000 || dmem_wdata !== 32'h55AA_55AA)
            begin n_err++; $display("FAIL b2b_second: got wreq=%b addr=%h wdata=%h want 1 00007000 55aa55aa", dmem_write_req, dmem_addr, dmem_wdata); end
        dmem_write_ack = 1'b1;
        next_cycle();
        dmem_write_ack = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rsp: got %b want 1", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [3:0] be; logic [31:0] a, d; int st, rs, ex;
        req_valid = 1'b1; mem_op_in = 3'd3; mem_size_in = 2'd0; addr_in = 32'h8002; wdata_in = 32'h5A;
        next_cycle();
        req_valid = 1'b0;
        #1;
        n_vec++; if (dmem_write_req !== 1'b1 || dmem_be !== 4'b0100) begin n_err++; $display("FAIL rst_mid_pre: got wreq=%b be=%b want 1 0100", dmem_write_req, dmem_be); end
        #1 reset_n = 1'b0;
        #1;
        n_vec++; if (dmem_write_req !== 1'b0 || dmem_be !== 4'b0000 || dbg_state !== ST_IDLE)
            begin n_err++; $display("FAIL rst_mid: got wreq=%b be=%b state=%0d want 0 0000 0", dmem_write_req, dmem_be, dbg_state); end
        @(negedge clk) reset_n = 1'b1;
        next_cycle();
        drive_load(3'd1, 2'd0, 32'h0000_8001, 32'h0000_7F00, 1, be, a, d, st, rs, ex);
        n_vec++; if (be !== 4'b0010 || d !== 32'h0000_007F || rs !== 1) begin n_err++; $display("FAIL rst_after_load: got be=%b data=%h rsp=%0d want 0010 0000007f 1", be, d, rs); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_lsu_ctrl.md
RISCV_LSU_CTRL -- requirements
Module: riscv_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles to wait for an ack before raising an access fault; legal range 1..65535.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  memory-stage request present.
REQ-005 mem_op_in  in  3  operation: NONE=0, LOAD=1, LOAD_UNSIGNED=2, STORE=3.
REQ-006 mem_size_in  in  2  size: BYTE=0, HALFWORD=1, WORD=2; code 3 is treated as WORD.
REQ-007 addr_in / wdata_in  in  32 each  byte address / store data, low-aligned.
REQ-008 dmem_addr  out  32  word-aligned bus address, equal to {addr[31:2],2'b00}.
REQ-009 dmem_wdata  out  32  store data replicated to all lanes.
REQ-010 dmem_be  out  4  byte enables.
REQ-011 dmem_read_req / dmem_write_req  out  1 each  bus request levels.
REQ-012 dmem_read_ack / dmem_write_ack  in  1 each  bus completion pulses.
REQ-013 dmem_rdata  in  32  read data, valid with dmem_read_ack.
REQ-014 stall_out  out  1  pipeline stall.
REQ-015 rsp_valid  out  1  one-cycle completion pulse.
REQ-016 load_data  out  32  extended load result, held until the next completion.
REQ-017 exc_valid  out  1  one-cycle exception pulse.
REQ-018 exc_cause  out  4  exception cause, held until the next exception.

Function
REQ-019 FSM states: IDLE, READ, WRITE, FAULT.
- IDLE accepts when req_valid=1 and op!=NONE.
- IDLE stays in IDLE when op=NONE; no outputs change.
REQ-020 Misalignment is defined as HALFWORD with addr[0]=1, or WORD with addr[1:0]!=0.
- A misaligned accept goes to FAULT.
- No bus request is issued.
REQ-021 FAULT lasts one cycle and pulses exc_valid with exc_cause=4 for a load or 6 for a store, then returns to IDLE.
REQ-022 An aligned accept registers addr, op, size and wdata, then enters READ (LOAD/LOAD_UNSIGNED) or WRITE (STORE).
- dmem_*_req is high from the next cycle until the ack cycle inclusive.
REQ-023 dmem_be is decoded from registered size and addr[1:0]:
- BYTE: 0001<<addr[1:0].
- HALFWORD: 0011<<{addr[1],1'b0}.
- WORD: 1111.
REQ-024 dmem_wdata replication:
- BYTE: {4{wdata[7:0]}}.
- HALFWORD: {2{wdata[15:0]}}.
- WORD: wdata.
REQ-025 Ack handling in READ/WRITE:
- The matching ack returns the FSM to IDLE and pulses rsp_valid in the following cycle.
- A READ ack registers load_data: the lane selected by addr[1:0] (BYTE) or addr[1] (HALFWORD), sign-extended for LOAD and zero-extended for LOAD_UNSIGNED; WORD is passed through unchanged.
REQ-026 A non-matching ack, or any ack in IDLE/FAULT, is ignored.
REQ-027 A 16-bit wait counter clears on entry to READ/WRITE and increments each cycle without an ack.
- When it reaches TIMEOUT_CYCLES, the request drops, the FSM goes to IDLE, and exc_valid pulses with exc_cause=5 (load) or 7 (store); rsp_valid stays low.
REQ-028 If an ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins.
REQ-029 stall_out is combinational: 1 in READ, WRITE and FAULT, and 1 in IDLE on an accept; 0 otherwise.
- stall_out is 0 in the rsp_valid cycle.
REQ-030 While stall_out=1, req inputs are held stable by the pipeline and are not re-sampled.
REQ-031 Back-to-back operation: a new accept is allowed in the same cycle as rsp_valid or exc_valid.

Reset
REQ-032 Reset (asynchronous, active-low) forces all of the following immediately, including mid-transaction; there is no bus-side completion after reset:
- State IDLE.
- dmem_read_req=0, dmem_write_req=0, dmem_be=0.
- rsp_valid=0, exc_valid=0, exc_cause=0, load_data=0.
- Wait counter cleared.
REQ-033 After reset release, the first accept is possible on the first rising edge.

Structure
REQ-034 The memory-type, memory-size and exception-cause constants, plus the FSM state enum, live in the shared global parameters package.
REQ-035 One sub-module, riscv_lsu_extend (combinational lane select and sign/zero extension), is instantiated once.

Verification
REQ-036 LOAD BYTE at addr 0x1003 with rdata=0x80FF_FF00 and ack after 2 wait cycles -> be=1000, load_data=0xFFFF_FF80, rsp_valid one cycle, stall_out high for exactly 4 cycles.
REQ-037 LOAD_UNSIGNED HALFWORD at addr 0x2002 with rdata=0xBEEF_1234 -> be=1100, load_data=0x0000_BEEF.
REQ-038 STORE HALFWORD at 0x3002 with wdata=0x0000_A5A5 -> dmem_wdata=0xA5A5_A5A5, be=1100, dmem_addr=0x3000; write_ack -> rsp_valid.
REQ-039 STORE WORD at 0x4001 -> no dmem_write_req, exc_valid with exc_cause=6 one cycle after accept.
REQ-040 LOAD WORD with TIMEOUT_CYCLES=4 and no ack -> exc_cause=5, req dropped; repeat with ack in the expiry cycle -> rsp_valid and no exception.
REQ-041 Assert reset_n low during WRITE -> req and be go to 0 immediately; after release, a new LOAD completes normally.
